// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the ID/EX operand stage.
//   XLEN, REG_AW   : datapath and register-address widths
//   alu_op_t       : 4-bit ALU operation code
//   alu_src_a_t    : ALU A operand select (rs1 / pc / zero / rs1)
//   alu_src_b_t    : ALU B operand select (rs2 / imm)
//   id_ex_t        : contents of the ID/EX pipeline register
//   stage_bubble() : the all-clear register image for an empty slot
//   fwd_hit()      : forwarding match test for one producer/source pair
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_SLL    = 4'b0010,
        ALU_SLT    = 4'b0011,
        ALU_SLTU   = 4'b0100,
        ALU_XOR    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_OR     = 4'b1000,
        ALU_AND    = 4'b1001,
        ALU_PASS_A = 4'b1010,
        ALU_PASS_B = 4'b1011,
        ALU_EQ     = 4'b1100,
        ALU_NE     = 4'b1101,
        ALU_GE     = 4'b1110,
        ALU_BR_CMP = 4'b1111
    } alu_op_t;

    // Code 11 is a second encoding of rs1 so the decoder never produces an
    // undefined select.
    typedef enum logic [1:0] {
        SRC_A_RS1     = 2'b00,
        SRC_A_PC      = 2'b01,
        SRC_A_ZERO    = 2'b10,
        SRC_A_RS1_ALT = 2'b11
    } alu_src_a_t;

    typedef enum logic {
        SRC_B_RS2 = 1'b0,
        SRC_B_IMM = 1'b1
    } alu_src_b_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd;
        alu_src_a_t        src_a;
        alu_src_b_t        src_b;
        alu_op_t           alu_ctrl;
        logic              reg_write;
        logic              mem_read;
    } id_ex_t;

    // A bubble clears the whole register, not just the control bits, so an
    // empty slot presents A=B=0 and can never match a forwarding source.
    function automatic id_ex_t stage_bubble();
        id_ex_t b;
        b           = '0;
        b.src_a     = SRC_A_RS1;
        b.src_b     = SRC_B_RS2;
        b.alu_ctrl  = ALU_ADD;
        return b;
    endfunction

    // x0 is hard-wired to zero, so a write to it is never a forwarding source.
    function automatic logic fwd_hit(
        input logic              we,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] rs
    );
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// ---------------------------------------------------------------------------
// ex_operand_stage_if
// Bundle of every signal between the operand stage and its neighbours.
//   ID side   : valid_in, stall, flush, pc_in, rs1/rs2 data and address,
//               imm_in, rd_addr_in, alu_src_a_in, alu_src_b_in, alu_ctrl_in,
//               reg_write_in, mem_read_in
//   Forwarding: mem_we/mem_rd/mem_data (EX/MEM), wb_we/wb_rd/wb_data (MEM/WB)
//   ALU side  : A, B, ALU_control, store_data
//   Pass-thru : valid_out, rd_out, reg_write_out, mem_read_out, pc_out
//   Hazard    : load_use_hazard back to ID
// The slave modport is the stage itself; master is the surrounding pipeline.
// ---------------------------------------------------------------------------
interface ex_operand_stage_if;
    import riscv_pkg::*;

    logic              valid_in;
    logic              stall;
    logic              flush;
    logic [XLEN-1:0]   pc_in;
    logic [XLEN-1:0]   rs1_data_in;
    logic [XLEN-1:0]   rs2_data_in;
    logic [XLEN-1:0]   imm_in;
    logic [REG_AW-1:0] rs1_addr_in;
    logic [REG_AW-1:0] rs2_addr_in;
    logic [REG_AW-1:0] rd_addr_in;
    alu_src_a_t        alu_src_a_in;
    alu_src_b_t        alu_src_b_in;
    alu_op_t           alu_ctrl_in;
    logic              reg_write_in;
    logic              mem_read_in;

    logic              mem_we;
    logic [REG_AW-1:0] mem_rd;
    logic [XLEN-1:0]   mem_data;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;

    logic [XLEN-1:0]   A;
    logic [XLEN-1:0]   B;
    alu_op_t           ALU_control;
    logic [XLEN-1:0]   store_data;
    logic              valid_out;
    logic [REG_AW-1:0] rd_out;
    logic              reg_write_out;
    logic              mem_read_out;
    logic [XLEN-1:0]   pc_out;
    logic              load_use_hazard;

    modport master (
        output valid_in, stall, flush, pc_in, rs1_data_in, rs2_data_in, imm_in,
               rs1_addr_in, rs2_addr_in, rd_addr_in, alu_src_a_in, alu_src_b_in,
               alu_ctrl_in, reg_write_in, mem_read_in,
               mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data,
        input  A, B, ALU_control, store_data, valid_out, rd_out, reg_write_out,
               mem_read_out, pc_out, load_use_hazard
    );

    modport slave (
        input  valid_in, stall, flush, pc_in, rs1_data_in, rs2_data_in, imm_in,
               rs1_addr_in, rs2_addr_in, rd_addr_in, alu_src_a_in, alu_src_b_in,
               alu_ctrl_in, reg_write_in, mem_read_in,
               mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data,
        output A, B, ALU_control, store_data, valid_out, rd_out, reg_write_out,
               mem_read_out, pc_out, load_use_hazard
    );

endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Forwarding select for one source operand.
//   i_rs_addr   : registered source register address
//   i_rf_data   : registered register-file value for that source
//   i_mem_*     : EX/MEM producer (write enable, rd, result)
//   i_wb_*      : MEM/WB producer (write enable, rd, result)
//   o_data      : the most recent value of the source register
// ---------------------------------------------------------------------------
module fwd_mux
    import riscv_pkg::*;
(
    input  logic [REG_AW-1:0] i_rs_addr,
    input  logic [XLEN-1:0]   i_rf_data,
    input  logic              i_mem_we,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic [XLEN-1:0]   i_mem_data,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic [XLEN-1:0]   o_data
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = fwd_hit(i_mem_we, i_mem_rd, i_rs_addr);
    assign w_wb_hit  = fwd_hit(i_wb_we,  i_wb_rd,  i_rs_addr);

    // EX/MEM holds the younger result, so it wins when both stages target
    // the same register.
    always_comb begin
        o_data = i_rf_data;
        if (w_mem_hit) begin
            o_data = i_mem_data;
        end else if (w_wb_hit) begin
            o_data = i_wb_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
// ID/EX pipeline register plus operand selection feeding the ALU.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous reset, active low; clears the whole stage
//   i_bus    : ex_operand_stage_if.slave, carrying the ID inputs, both
//              forwarding sources, ALU operands/control, the registered
//              pass-through fields and load_use_hazard back to ID
// ID inputs reach the ALU operands one cycle after capture. Forwarding and
// operand selection are combinational on the registered stage contents.
// ---------------------------------------------------------------------------
module ex_operand_stage
    import riscv_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    ex_operand_stage_if.slave     i_bus
);

    id_ex_t          r_stage;
    id_ex_t          w_stage_next;
    id_ex_t          w_captured;
    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;

    // Image of the ID inputs as they would be stored this edge.
    always_comb begin
        w_captured           = stage_bubble();
        w_captured.valid     = 1'b1;
        w_captured.pc        = i_bus.pc_in;
        w_captured.rs1_data  = i_bus.rs1_data_in;
        w_captured.rs2_data  = i_bus.rs2_data_in;
        w_captured.imm       = i_bus.imm_in;
        w_captured.rs1_addr  = i_bus.rs1_addr_in;
        w_captured.rs2_addr  = i_bus.rs2_addr_in;
        w_captured.rd        = i_bus.rd_addr_in;
        w_captured.src_a     = i_bus.alu_src_a_in;
        w_captured.src_b     = i_bus.alu_src_b_in;
        w_captured.alu_ctrl  = i_bus.alu_ctrl_in;
        w_captured.reg_write = i_bus.reg_write_in;
        w_captured.mem_read  = i_bus.mem_read_in;
    end

    // Flush beats stall so a load-use bubble is inserted even while the
    // pipeline is otherwise frozen.
    always_comb begin
        w_stage_next = r_stage;
        if (i_bus.flush) begin
            w_stage_next = stage_bubble();
        end else if (!i_bus.stall) begin
            if (i_bus.valid_in) begin
                w_stage_next = w_captured;
            end else begin
                w_stage_next = stage_bubble();
            end
        end
    end

    // Stage register; reset discards any in-flight instruction at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stage <= stage_bubble();
        end else begin
            r_stage <= w_stage_next;
        end
    end

    fwd_mux u_fwd_rs1 (
        .i_rs_addr  (r_stage.rs1_addr),
        .i_rf_data  (r_stage.rs1_data),
        .i_mem_we   (i_bus.mem_we),
        .i_mem_rd   (i_bus.mem_rd),
        .i_mem_data (i_bus.mem_data),
        .i_wb_we    (i_bus.wb_we),
        .i_wb_rd    (i_bus.wb_rd),
        .i_wb_data  (i_bus.wb_data),
        .o_data     (w_rs1_fwd)
    );

    fwd_mux u_fwd_rs2 (
        .i_rs_addr  (r_stage.rs2_addr),
        .i_rf_data  (r_stage.rs2_data),
        .i_mem_we   (i_bus.mem_we),
        .i_mem_rd   (i_bus.mem_rd),
        .i_mem_data (i_bus.mem_data),
        .i_wb_we    (i_bus.wb_we),
        .i_wb_rd    (i_bus.wb_rd),
        .i_wb_data  (i_bus.wb_data),
        .o_data     (w_rs2_fwd)
    );

    // Operand muxes sit after forwarding; the zero select serves LUI.
    always_comb begin
        w_a = w_rs1_fwd;
        case (r_stage.src_a)
            SRC_A_PC:   w_a = r_stage.pc;
            SRC_A_ZERO: w_a = '0;
            default:    w_a = w_rs1_fwd;
        endcase
        w_b = (r_stage.src_b == SRC_B_IMM) ? r_stage.imm : w_rs2_fwd;
    end

    assign i_bus.A             = w_a;
    assign i_bus.B             = w_b;
    assign i_bus.ALU_control   = r_stage.alu_ctrl;
    assign i_bus.store_data    = w_rs2_fwd;
    assign i_bus.valid_out     = r_stage.valid;
    assign i_bus.rd_out        = r_stage.rd;
    assign i_bus.reg_write_out = r_stage.reg_write;
    assign i_bus.mem_read_out  = r_stage.mem_read;
    assign i_bus.pc_out        = r_stage.pc;

    // A load's data is not ready for forwarding until MEM/WB, so an ID
    // instruction reading its rd must wait one cycle.
    assign i_bus.load_use_hazard = r_stage.valid && r_stage.mem_read
                                   && (r_stage.rd != '0)
                                   && ((r_stage.rd == i_bus.rs1_addr_in)
                                       || (r_stage.rd == i_bus.rs2_addr_in));

endmodule

// File: tb/tb_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_operand_stage
// Self-checking bench for ex_operand_stage: a vector table for the main
// datapath plus hand-written sequences for load-use, stall/flush and reset.
// ---------------------------------------------------------------------------
module tb_ex_operand_stage;
    import riscv_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ex_operand_stage_if bus();

    ex_operand_stage dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rd;
        alu_src_a_t  srcA;
        alu_src_b_t  srcB;
        alu_op_t     op;
        logic        regWrite, memRead;
        logic        memWe;
        logic [4:0]  memRd;
        logic [31:0] memData;
        logic        wbWe;
        logic [4:0]  wbRd;
        logic [31:0] wbData;
        logic [31:0] expA, expB, expStore;
    } vec_t;

    typedef struct {
        logic [31:0] a, b, store, pc;
        alu_op_t     ctrl;
        logic        valid, regWrite, memRead;
        logic [4:0]  rd;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mkVec(
        input logic valid, input logic [31:0] pc, rs1d, rs2d, imm,
        input logic [4:0] rs1a, rs2a, rd, input alu_src_a_t sa, input alu_src_b_t sb,
        input alu_op_t op, input logic rw, mr,
        input logic memWe, input logic [4:0] memRd, input logic [31:0] memData,
        input logic wbWe, input logic [4:0] wbRd, input logic [31:0] wbData,
        input logic [31:0] expA, expB, expStore);
        vec_t v;
        v.valid = valid; v.pc = pc; v.rs1d = rs1d; v.rs2d = rs2d; v.imm = imm;
        v.rs1a = rs1a; v.rs2a = rs2a; v.rd = rd; v.srcA = sa; v.srcB = sb; v.op = op;
        v.regWrite = rw; v.memRead = mr;
        v.memWe = memWe; v.memRd = memRd; v.memData = memData;
        v.wbWe = wbWe; v.wbRd = wbRd; v.wbData = wbData;
        v.expA = expA; v.expB = expB; v.expStore = expStore;
        return v;
    endfunction

    // Pass-through fields follow the instruction when valid, else a bubble.
    function automatic exp_t expectFrom(input vec_t v);
        exp_t e;
        e.a = v.expA; e.b = v.expB; e.store = v.expStore;
        e.valid    = v.valid;
        e.pc       = v.valid ? v.pc : 32'h0;
        e.ctrl     = v.valid ? v.op : ALU_ADD;
        e.rd       = v.valid ? v.rd : 5'd0;
        e.regWrite = v.valid ? v.regWrite : 1'b0;
        e.memRead  = v.valid ? v.memRead : 1'b0;
        return e;
    endfunction

    function automatic exp_t bubbleExp();
        exp_t e;
        e.a = 32'h0; e.b = 32'h0; e.store = 32'h0; e.pc = 32'h0;
        e.ctrl = ALU_ADD; e.valid = 1'b0; e.regWrite = 1'b0; e.memRead = 1'b0; e.rd = 5'd0;
        return e;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compareOutputs(input string tag, input exp_t e);
        checkVal({tag, ".A"},          bus.A,             e.a);
        checkVal({tag, ".B"},          bus.B,             e.b);
        checkVal({tag, ".store"},      bus.store_data,    e.store);
        checkVal({tag, ".ctrl"},       32'(bus.ALU_control), 32'(e.ctrl));
        checkVal({tag, ".valid"},      32'(bus.valid_out),   32'(e.valid));
        checkVal({tag, ".rd"},         32'(bus.rd_out),      32'(e.rd));
        checkVal({tag, ".reg_write"},  32'(bus.reg_write_out), 32'(e.regWrite));
        checkVal({tag, ".mem_read"},   32'(bus.mem_read_out),  32'(e.memRead));
        checkVal({tag, ".pc"},         bus.pc_out,        e.pc);
    endtask

    // Drives one instruction plus forwarding sources and queues its result.
    task automatic applyStimulus(input vec_t v, input logic st, input logic fl, input exp_t e);
        @(negedge clk);
        bus.valid_in     = v.valid;
        bus.pc_in        = v.pc;
        bus.rs1_data_in  = v.rs1d;
        bus.rs2_data_in  = v.rs2d;
        bus.imm_in       = v.imm;
        bus.rs1_addr_in  = v.rs1a;
        bus.rs2_addr_in  = v.rs2a;
        bus.rd_addr_in   = v.rd;
        bus.alu_src_a_in = v.srcA;
        bus.alu_src_b_in = v.srcB;
        bus.alu_ctrl_in  = v.op;
        bus.reg_write_in = v.regWrite;
        bus.mem_read_in  = v.memRead;
        bus.mem_we       = v.memWe;
        bus.mem_rd       = v.memRd;
        bus.mem_data     = v.memData;
        bus.wb_we        = v.wbWe;
        bus.wb_rd        = v.wbRd;
        bus.wb_data      = v.wbData;
        bus.stall        = st;
        bus.flush        = fl;
        sbq.push_back(e);
    endtask

    // One cycle of latency: the queued result is due just after the next edge.
    task automatic checkOutput(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s.scoreboard: got empty queue expected an entry", tag);
        end else begin
            e = sbq.pop_front();
            compareOutputs(tag, e);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        exp_t eHold;

        vecs[0] = mkVec(1, 32'h0,   32'd10,   32'd20, 32'h0,        5'd1, 5'd2, 5'd3,  SRC_A_RS1,     SRC_B_RS2, ALU_ADD,    1, 0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    32'd10,   32'd20,       32'd20);
        vecs[1] = mkVec(1, 32'h4,   32'h55,   32'h66, 32'h0,        5'd5, 5'd6, 5'd10, SRC_A_RS1,     SRC_B_RS2, ALU_ADD,    1, 0, 1, 5'd5, 32'hAA,   1, 5'd5, 32'hBB,   32'hAA,   32'h66,       32'h66);
        vecs[2] = mkVec(1, 32'h8,   32'h55,   32'h66, 32'h0,        5'd5, 5'd6, 5'd10, SRC_A_RS1,     SRC_B_RS2, ALU_ADD,    1, 0, 0, 5'd5, 32'hAA,   1, 5'd5, 32'hBB,   32'hBB,   32'h66,       32'h66);
        vecs[3] = mkVec(1, 32'hC,   32'h1234, 32'h66, 32'h0,        5'd0, 5'd6, 5'd0,  SRC_A_RS1,     SRC_B_RS2, ALU_ADD,    0, 0, 1, 5'd0, 32'hAA,   1, 5'd0, 32'hBB,   32'h1234, 32'h66,       32'h66);
        vecs[4] = mkVec(1, 32'h100, 32'h11,   32'h99, 32'hFFFFFFF6, 5'd1, 5'd9, 5'd11, SRC_A_PC,      SRC_B_IMM, ALU_SUB,    1, 0, 0, 5'd0, 32'h0,    1, 5'd9, 32'hCAFE, 32'h100,  32'hFFFFFFF6, 32'hCAFE);
        vecs[5] = mkVec(1, 32'h104, 32'h77,   32'h0,  32'h12345000, 5'd2, 5'd0, 5'd12, SRC_A_ZERO,    SRC_B_IMM, ALU_PASS_B, 1, 0, 1, 5'd2, 32'hEE,   0, 5'd0, 32'h0,    32'h0,    32'h12345000, 32'h0);
        vecs[6] = mkVec(1, 32'h108, 32'h30,   32'h30, 32'h0,        5'd3, 5'd3, 5'd13, SRC_A_RS1_ALT, SRC_B_RS2, ALU_XOR,    1, 0, 1, 5'd3, 32'hDEAD, 1, 5'd3, 32'hBEEF, 32'hDEAD, 32'hDEAD,     32'hDEAD);
        vecs[7] = mkVec(1, 32'h10C, 32'h1,    32'h2,  32'h0,        5'd4, 5'd8, 5'd14, SRC_A_RS1,     SRC_B_RS2, ALU_OR,     1, 0, 1, 5'd4, 32'h44,   1, 5'd8, 32'h88,   32'h44,   32'h88,       32'h88);
        vecs[8] = mkVec(0, 32'h110, 32'hAB,   32'hCD, 32'h5,        5'd5, 5'd5, 5'd15, SRC_A_PC,      SRC_B_IMM, ALU_AND,    1, 1, 1, 5'd5, 32'hAA,   1, 5'd5, 32'hBB,   32'h0,    32'h0,        32'h0);
        vecs[9] = mkVec(1, 32'h114, 32'h5,    32'h6,  32'h0,        5'd5, 5'd6, 5'd16, SRC_A_RS1,     SRC_B_RS2, ALU_SLT,    1, 0, 0, 5'd5, 32'hAA,   0, 5'd6, 32'hBB,   32'h5,    32'h6,        32'h6);

        // Reset state with quiet inputs.
        v = mkVec(0, 0, 0, 0, 0, 0, 0, 0, SRC_A_RS1, SRC_B_RS2, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.valid_in = 0; bus.pc_in = 0; bus.rs1_data_in = 0; bus.rs2_data_in = 0; bus.imm_in = 0;
        bus.rs1_addr_in = 0; bus.rs2_addr_in = 0; bus.rd_addr_in = 0;
        bus.alu_src_a_in = SRC_A_RS1; bus.alu_src_b_in = SRC_B_RS2; bus.alu_ctrl_in = ALU_ADD;
        bus.reg_write_in = 0; bus.mem_read_in = 0; bus.stall = 0; bus.flush = 0;
        bus.mem_we = 0; bus.mem_rd = 0; bus.mem_data = 0; bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0;
        #2;
        compareOutputs("reset", bubbleExp());
        checkVal("reset.hazard", 32'(bus.load_use_hazard), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Main datapath and forwarding table.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], 1'b0, 1'b0, expectFrom(vecs[i]));
            checkOutput($sformatf("vec%0d", i));
        end

        // Load in stage whose rd matches ID rs2 -> hazard, then flush clears it.
        v = mkVec(1, 32'h200, 32'h0, 32'h0, 32'h0, 5'd3, 5'd7, 5'd7, SRC_A_RS1, SRC_B_RS2, ALU_ADD, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        applyStimulus(v, 1'b0, 1'b0, expectFrom(v));
        checkOutput("load");
        checkVal("hazard.rs2", 32'(bus.load_use_hazard), 32'd1);
        bus.rs1_addr_in = 5'd7; bus.rs2_addr_in = 5'd8;
        #1;
        checkVal("hazard.rs1", 32'(bus.load_use_hazard), 32'd1);
        bus.rs1_addr_in = 5'd8;
        #1;
        checkVal("hazard.nomatch", 32'(bus.load_use_hazard), 32'd0);
        applyStimulus(v, 1'b0, 1'b1, bubbleExp());
        checkOutput("hazard_flush");
        checkVal("hazard.after_flush", 32'(bus.load_use_hazard), 32'd0);

        // A load to x0 and a non-load to x7 must not raise the hazard.
        v = mkVec(1, 32'h204, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, SRC_A_RS1, SRC_B_RS2, ALU_ADD, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        applyStimulus(v, 1'b0, 1'b0, expectFrom(v));
        checkOutput("load_x0");
        checkVal("hazard.x0", 32'(bus.load_use_hazard), 32'd0);
        v = mkVec(1, 32'h208, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7, SRC_A_RS1, SRC_B_RS2, ALU_ADD, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        applyStimulus(v, 1'b0, 1'b0, expectFrom(v));
        checkOutput("alu_rd7");
        checkVal("hazard.nonload", 32'(bus.load_use_hazard), 32'd0);

        // Stall for three cycles with changing inputs, then stall+flush.
        applyStimulus(vecs[0], 1'b0, 1'b0, expectFrom(vecs[0]));
        checkOutput("stall_load");
        eHold = expectFrom(vecs[0]);
        for (int k = 0; k < 3; k++) begin
            v = mkVec(1, $urandom, $urandom, $urandom, $urandom, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
                      5'($urandom_range(1, 31)), SRC_A_PC, SRC_B_IMM, ALU_SRA, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            applyStimulus(v, 1'b1, 1'b0, eHold);
            checkOutput($sformatf("stall%0d", k));
        end
        applyStimulus(v, 1'b1, 1'b1, bubbleExp());
        checkOutput("stall_flush");

        // Asynchronous reset between edges with a valid instruction loaded.
        applyStimulus(vecs[4], 1'b0, 1'b0, expectFrom(vecs[4]));
        checkOutput("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        compareOutputs("async_reset", bubbleExp());
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(vecs[0], 1'b0, 1'b0, expectFrom(vecs[0]));
        checkOutput("post_reset");

        checkVal("scoreboard.empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
